// File: rtl/sram_fifo_controller.sv
// sram_fifo_controller: FIFO controller for a 256x16 single-port SRAM macro.
// SRAM commands are registered on the rising edge of Clk_In. The SRAM samples
// them on the falling edge, and read data is captured on the next rising edge.
`timescale 1ns/1ps
module sram_fifo_controller #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic                  Flush_In,
    input  logic                  Push_Valid,
    input  logic [DATA_WIDTH-1:0] Push_Data,
    output logic                  Push_Ready,
    input  logic                  Pop_Req,
    output logic                  Pop_Ready,
    output logic [DATA_WIDTH-1:0] Pop_Data,
    output logic                  Pop_Valid,
    output logic [ADDR_WIDTH:0]   Count,
    output logic                  Full,
    output logic                  Empty,
    output logic [DATA_WIDTH-1:0] SRAM_Data_In,
    output logic [ADDR_WIDTH-1:0] SRAM_Address,
    output logic                  SRAM_Write_Enable,
    output logic                  SRAM_Read_Enable,
    input  logic [DATA_WIDTH-1:0] SRAM_Data_Out
);

    typedef enum logic { GRANT_POP = 1'b0, GRANT_PUSH = 1'b1 } grant_e;

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    grant_e                last_grant_q, last_grant_d;
    logic                  rd_pending_q, rd_pending_d;
    logic                  pop_valid_q, pop_valid_d;
    logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
    logic                  sram_we_q, sram_we_d;
    logic                  sram_re_q, sram_re_d;
    logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_WIDTH-1:0] sram_din_q, sram_din_d;

    logic full, empty, push_elig, pop_elig, push_rdy, pop_rdy, push_acc, pop_acc;

    // Round-robin arbitration of the single SRAM port between push and pop.
    always_comb begin
        full      = (count_q == FULL_COUNT);
        empty     = (count_q == '0);
        push_elig = Push_Valid && !full;
        pop_elig  = Pop_Req && !empty;
        push_rdy  = !Flush_In && !full && !(pop_elig && (last_grant_q == GRANT_PUSH));
        pop_rdy   = !Flush_In && !empty && !(push_elig && (last_grant_q == GRANT_POP));
        push_acc  = Push_Valid && push_rdy;
        pop_acc   = Pop_Req && pop_rdy;
    end

    // Next-state: flush beats push/pop; read data is captured only behind an issued read.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;
        rd_pending_d = 1'b0;
        pop_valid_d  = rd_pending_q;
        pop_data_d   = rd_pending_q ? SRAM_Data_Out : pop_data_q;
        sram_we_d    = 1'b0;
        sram_re_d    = 1'b0;
        sram_addr_d  = sram_addr_q;
        sram_din_d   = sram_din_q;
        if (Flush_In) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            last_grant_d = GRANT_POP;
            pop_valid_d  = 1'b0;
            pop_data_d   = pop_data_q;
        end else if (push_acc) begin
            sram_we_d    = 1'b1;
            sram_addr_d  = wr_ptr_q;
            sram_din_d   = Push_Data;
            wr_ptr_d     = wr_ptr_q + ADDR_WIDTH'(1);
            count_d      = count_q + (ADDR_WIDTH + 1)'(1);
            last_grant_d = GRANT_PUSH;
        end else if (pop_acc) begin
            sram_re_d    = 1'b1;
            sram_addr_d  = rd_ptr_q;
            rd_ptr_d     = rd_ptr_q + ADDR_WIDTH'(1);
            count_d      = count_q - (ADDR_WIDTH + 1)'(1);
            last_grant_d = GRANT_POP;
            rd_pending_d = 1'b1;
        end
    end

    // State and registered SRAM command/pop outputs, asynchronously reset.
    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            last_grant_q <= GRANT_POP;
            rd_pending_q <= 1'b0;
            pop_valid_q  <= 1'b0;
            pop_data_q   <= '0;
            sram_we_q    <= 1'b0;
            sram_re_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_din_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
            rd_pending_q <= rd_pending_d;
            pop_valid_q  <= pop_valid_d;
            pop_data_q   <= pop_data_d;
            sram_we_q    <= sram_we_d;
            sram_re_q    <= sram_re_d;
            sram_addr_q  <= sram_addr_d;
            sram_din_q   <= sram_din_d;
        end
    end

    assign Push_Ready        = push_rdy;
    assign Pop_Ready         = pop_rdy;
    assign Pop_Data          = pop_data_q;
    assign Pop_Valid         = pop_valid_q;
    assign Count             = count_q;
    assign Full              = full;
    assign Empty             = empty;
    assign SRAM_Data_In      = sram_din_q;
    assign SRAM_Address      = sram_addr_q;
    assign SRAM_Write_Enable = sram_we_q;
    assign SRAM_Read_Enable  = sram_re_q;

endmodule

// File: tb/tb_sram_fifo_controller.sv
// tb_sram_fifo_controller: scoreboard bench with a queue-based FIFO model and
// a behavioural falling-edge SRAM.
`timescale 1ns/1ps
module tb_sram_fifo_controller;

    logic        Clk_In = 1'b0;
    logic        Reset_In, Flush_In, Push_Valid, Pop_Req;
    logic [15:0] Push_Data;
    logic        Push_Ready, Pop_Ready, Pop_Valid, Full, Empty;
    logic [15:0] Pop_Data, SRAM_Data_In, SRAM_Data_Out;
    logic [8:0]  Count;
    logic [7:0]  SRAM_Address;
    logic        SRAM_Write_Enable, SRAM_Read_Enable;

    sram_fifo_controller #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
        .Clk_In(Clk_In), .Reset_In(Reset_In), .Flush_In(Flush_In),
        .Push_Valid(Push_Valid), .Push_Data(Push_Data), .Push_Ready(Push_Ready),
        .Pop_Req(Pop_Req), .Pop_Ready(Pop_Ready), .Pop_Data(Pop_Data), .Pop_Valid(Pop_Valid),
        .Count(Count), .Full(Full), .Empty(Empty),
        .SRAM_Data_In(SRAM_Data_In), .SRAM_Address(SRAM_Address),
        .SRAM_Write_Enable(SRAM_Write_Enable), .SRAM_Read_Enable(SRAM_Read_Enable),
        .SRAM_Data_Out(SRAM_Data_Out)
    );

    always #5 Clk_In = ~Clk_In;

    // Behavioural SRAM: samples on the falling edge, garbage on the bus when not reading.
    logic [15:0] mem [256];
    always @(negedge Clk_In) begin
        if (SRAM_Write_Enable) mem[SRAM_Address] <= SRAM_Data_In;
        if (SRAM_Read_Enable) SRAM_Data_Out <= mem[SRAM_Address];
        else SRAM_Data_Out <= 16'($urandom);
    end

    typedef struct {
        int tgt;
        bit we, re;
        int addr, din;
        bit pv;
        int pd;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0, fails = 0, cyc = 0;

    // Reference model state
    int mq[$];
    int wr_i, rd_i, hold_addr, hold_din, prev_data;
    bit lg, prev_pop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        wr_i = 0; rd_i = 0; hold_addr = 0; hold_din = 0; prev_data = 0;
        lg = 0; prev_pop = 0;
    endtask

    // One clock of stimulus: called at posedge+1, returns at next posedge+1.
    task automatic step(input bit pv, input int pd, input bit pr, input bit fl);
        exp_t e;
        bit full_m, empty_m, pe, oe, epr, eor, ap, ao;
        Push_Valid = pv; Push_Data = 16'(pd); Pop_Req = pr; Flush_In = fl;
        #1;
        full_m  = (mq.size() == 256);
        empty_m = (mq.size() == 0);
        pe  = pv && !full_m;
        oe  = pr && !empty_m;
        epr = !fl && !full_m && !(oe && lg);
        eor = !fl && !empty_m && !(pe && !lg);
        chk("push_ready", 32'(Push_Ready), 32'(epr));
        chk("pop_ready", 32'(Pop_Ready), 32'(eor));
        ap = pv && epr;
        ao = pr && eor;
        e.tgt = cyc + 1;
        e.pv  = prev_pop && !fl;
        e.pd  = prev_data;
        e.we  = 0;
        e.re  = 0;
        prev_pop = 0;
        if (fl) begin
            mq.delete(); wr_i = 0; rd_i = 0; lg = 0;
        end else if (ap) begin
            e.we = 1; hold_addr = wr_i; hold_din = pd & 16'hFFFF;
            mq.push_back(pd & 16'hFFFF);
            wr_i = (wr_i + 1) % 256; lg = 1;
        end else if (ao) begin
            e.re = 1; hold_addr = rd_i;
            prev_data = mq.pop_front(); prev_pop = 1;
            rd_i = (rd_i + 1) % 256; lg = 0;
        end
        e.addr = hold_addr;
        e.din  = hold_din;
        e.cnt  = mq.size();
        exp_q.push_back(e);
        @(posedge Clk_In); #1;
    endtask

    // Pop accepted at the previous edge, then reset lands before the next edge.
    task automatic reset_mid();
        exp_t e;
        @(negedge Clk_In); #1;
        Push_Valid = 0; Pop_Req = 0; Flush_In = 0;
        Reset_In = 1;
        model_reset();
        e = '{tgt: cyc + 1, we: 0, re: 0, addr: 0, din: 0, pv: 0, pd: 0, cnt: 0};
        exp_q.push_back(e);
        @(posedge Clk_In); #1;
        Reset_In = 0;
    endtask

    // Monitor: compare registered outputs against the expectation for this edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk_In);
            cyc++;
            #3;
            while (exp_q.size() > 0 && exp_q[0].tgt <= cyc) begin
                e = exp_q.pop_front();
                chk("edge_align", 32'(e.tgt), 32'(cyc));
                chk("sram_we", 32'(SRAM_Write_Enable), 32'(e.we));
                chk("sram_re", 32'(SRAM_Read_Enable), 32'(e.re));
                chk("en_exclusive", 32'(SRAM_Write_Enable && SRAM_Read_Enable), 32'(0));
                chk("sram_addr", 32'(SRAM_Address), 32'(e.addr));
                chk("sram_din", 32'(SRAM_Data_In), 32'(e.din));
                chk("pop_valid", 32'(Pop_Valid), 32'(e.pv));
                if (e.pv) chk("pop_data", 32'(Pop_Data), 32'(e.pd));
                chk("count", 32'(Count), 32'(e.cnt));
                chk("full", 32'(Full), 32'(e.cnt == 256));
                chk("empty", 32'(Empty), 32'(e.cnt == 0));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_In = 1; Flush_In = 0; Push_Valid = 0; Pop_Req = 0; Push_Data = '0;
        model_reset();
        repeat (3) @(posedge Clk_In);
        #1;
        Reset_In = 0;
        chk("rst_count", 32'(Count), 32'(0));
        chk("rst_empty", 32'(Empty), 32'(1));
        chk("rst_full", 32'(Full), 32'(0));
        chk("rst_pop_valid", 32'(Pop_Valid), 32'(0));
        chk("rst_pop_data", 32'(Pop_Data), 32'(0));
        chk("rst_we", 32'(SRAM_Write_Enable), 32'(0));
        chk("rst_re", 32'(SRAM_Read_Enable), 32'(0));
        chk("rst_addr", 32'(SRAM_Address), 32'(0));
        chk("rst_din", 32'(SRAM_Data_In), 32'(0));

        // Three pushes then three back-to-back pops
        step(1, 'h1111, 0, 0);
        step(1, 'h2222, 0, 0);
        step(1, 'h3333, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // Fill to 256, refused 257th, pop one, wrap-around push, drain
        step(0, 0, 0, 1);
        for (int i = 0; i < 256; i++) step(1, i, 0, 0);
        step(1, 'h7777, 0, 0);
        step(0, 0, 1, 0);
        step(1, 'hBEEF, 0, 0);
        for (int i = 0; i < 256; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // Contention at Count = 5 with last grant = pop
        step(0, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(1, 'h100 + i, 0, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 8; i++) step(1, 'h200 + i, 1, 0);
        step(0, 0, 0, 0);

        // Read-after-write
        step(0, 0, 0, 1);
        step(1, 'hA5A5, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // In-flight read dropped by reset, then by flush
        for (int i = 0; i < 4; i++) step(1, 'h300 + i, 0, 0);
        step(0, 0, 1, 0);
        reset_mid();
        step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 'h400 + i, 0, 0);
        step(0, 0, 1, 0);
        step(1, 'h4444, 1, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 55, int'($urandom_range(0, 65535)),
                 $urandom_range(0, 99) < 50, $urandom_range(0, 199) == 0);
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        @(posedge Clk_In); #5;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_fifo_controller.md
Name: sram_fifo_controller

Overview:
- Upstream controller that turns the 256x16 single-port SRAM macro into a FIFO with valid/ready push and pop interfaces.
- Owns the SRAM pins and arbitrates the single port: at most one read or one write per clock.
- The SRAM samples on the falling edge of Clk_In. This block registers all SRAM commands on the rising edge, giving half a cycle of setup.
- Captures SRAM read data on the next rising edge.

Parameters:
- DATA_WIDTH, 16, word width; must match SRAM data width.
- ADDR_WIDTH, 8, SRAM address width; FIFO depth = 2**ADDR_WIDTH = 256.

Ports:
- Clk_In  in  1  clock; block uses rising edge, SRAM uses falling edge.
- Reset_In  in  1  reset, asynchronous, active-high.
- Flush_In  in  1  synchronous clear of FIFO contents (rising edge).
- Push_Valid  in  1  producer has a word.
- Push_Data  in  DATA_WIDTH  word to store.
- Push_Ready  out  1  combinational; push accepted at the edge where Push_Valid && Push_Ready.
- Pop_Req  in  1  consumer requests a word.
- Pop_Ready  out  1  combinational; pop accepted at the edge where Pop_Req && Pop_Ready.
- Pop_Data  out  DATA_WIDTH  registered read data.
- Pop_Valid  out  1  registered; Pop_Data valid for this one cycle.
- Count  out  ADDR_WIDTH+1  registered occupancy, 0..256.
- Full  out  1  Count == 256.
- Empty  out  1  Count == 0.
- SRAM_Data_In  out  DATA_WIDTH  registered write data to SRAM.
- SRAM_Address  out  ADDR_WIDTH  registered SRAM address.
- SRAM_Write_Enable  out  1  registered.
- SRAM_Read_Enable  out  1  registered.
- SRAM_Data_Out  in  DATA_WIDTH  SRAM read data; may be Z when not reading.

Behaviour:
- State registers:
  - Wr_Ptr, Rd_Ptr (ADDR_WIDTH, wrap 255->0).
  - Count.
  - Last_Grant (0 = pop, 1 = push).
  - Rd_Pending (read issued last edge).
- Reset values (async, Reset_In high):
  - Wr_Ptr = Rd_Ptr = 0; Count = 0, so Empty = 1 and Full = 0.
  - Last_Grant = 0; Rd_Pending = 0.
  - Pop_Valid = 0; Pop_Data = 0.
  - SRAM_Write_Enable = 0; SRAM_Read_Enable = 0; SRAM_Address = 0; SRAM_Data_In = 0.
- Eligibility:
  - Push eligible = Push_Valid && !Full.
  - Pop eligible = Pop_Req && !Empty.
- Arbitration (combinational):
  - Only one eligible: it is granted.
  - Both eligible: grant push if Last_Grant == 0, else grant pop (round-robin).
  - Push_Ready = !Full && !(pop eligible && Last_Grant == 0 is false); equivalently Push_Ready is 0 only when Full, or when pop is eligible and Last_Grant == 1.
  - Pop_Ready = !Empty && !(push eligible && Last_Grant == 0).
  - Never are both accepted in the same cycle.
- Accepted push at edge k:
  - SRAM_Write_Enable <= 1; SRAM_Address <= Wr_Ptr; SRAM_Data_In <= Push_Data.
  - Wr_Ptr++; Count++; Last_Grant <= 1.
  - SRAM writes at the falling edge k+1/2.
- Accepted pop at edge k:
  - SRAM_Read_Enable <= 1; SRAM_Address <= Rd_Ptr.
  - Rd_Ptr++; Count--; Last_Grant <= 0; Rd_Pending <= 1.
- Read return:
  - SRAM drives data at falling edge k+1/2.
  - At edge k+1, if Rd_Pending: Pop_Data <= SRAM_Data_Out and Pop_Valid <= 1; otherwise Pop_Valid <= 0 and Pop_Data holds.
  - Latency: Pop_Valid high exactly 1 cycle after the accepting edge.
  - Back-to-back pops give 1 word/cycle.
- No grant at an edge: both SRAM enables <= 0; address and data hold.
- Invariant: SRAM_Read_Enable and SRAM_Write_Enable are never both 1. The SRAM gives read priority, so this is mandatory.
- SRAM_Data_Out is ignored unless Rd_Pending; Z is never captured.
- Read-after-write:
  - A word pushed at edge k is poppable at edge k+1, because Empty deasserts after edge k.
  - The SRAM write at k+1/2 precedes the read at k+3/2.
- Full = 256: Push_Ready = 0. A pop is accepted if requested.
- Empty: Pop_Ready = 0. A push is accepted if offered.
- Pointer wrap: Wr_Ptr and Rd_Ptr wrap 255->0 with no gap. Count distinguishes full from empty.
- Flush_In (synchronous, highest priority over push/pop):
  - Wr_Ptr = Rd_Ptr = Count = 0; Last_Grant = 0.
  - Both SRAM enables <= 0; Rd_Pending <= 0; Pop_Valid <= 0.
  - Push_Ready = Pop_Ready = 0 while Flush_In is high.
- Reset mid-operation: an in-flight read is dropped and no Pop_Valid follows. Contents are logically discarded; SRAM data is not cleared.

Test Plan:
- Reset, then push 0x1111, 0x2222, 0x3333 on consecutive cycles -> SRAM_Write_Enable pulses at addresses 0,1,2; Count = 3; Empty = 0.
- Pop 3 back-to-back -> SRAM_Read_Enable at addresses 0,1,2; Pop_Valid high 3 cycles, each 1 cycle after acceptance; Pop_Data = 0x1111, 0x2222, 0x3333; Empty = 1.
- Push 256 words (value = index) -> Full = 1, Push_Ready = 0 on the 257th attempt. Pop 1 -> 0x0000, Full = 0. Push 0xBEEF -> written at address 0 (wrap). Drain -> 1..255 then 0xBEEF.
- Push_Valid and Pop_Req held with Count = 5 -> grants alternate push/pop starting with push; enables never both high; Count oscillates 6,5,6,5.
- Push 0xA5A5 at edge k, Pop_Req from edge k+1 -> pop accepted at k+1; Pop_Data = 0xA5A5 with Pop_Valid at k+2.
- With 4 words, pop accepted, then Reset_In asserted before the next edge -> Pop_Valid stays 0; Count = 0; enables 0. Repeat with Flush_In instead -> same result, synchronous.
